// File: rtl/hpdmc_odatapath16.sv
// Write datapath for the 16-bit DDR controller.
// Buffers 32-bit write words and sequences DQ/DQS/DM enables and ODDR2 data
// through the preamble, burst and postamble of a write.
module hpdmc_odatapath16 #(
  parameter int unsigned BURST_WORDS   = 4,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned WRITE_LATENCY = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  input  logic        wvalid,
  output logic        wready,
  input  logic        write_go,
  output logic        write_ok,
  output logic        busy,
  output logic        proto_err,
  output logic [15:0] d0,
  output logic [15:0] d1,
  output logic [1:0]  dm0,
  output logic [1:0]  dm1,
  output logic        dq_oe,
  output logic        dqs_oe,
  output logic        dqs_toggle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BURST_WORDS);
  localparam int unsigned EW = 36;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_DATA, S_POST} state_t;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, go_ok;
  logic [EW-1:0] head;

  state_t        state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic [15:0]   d0_nxt, d1_nxt;
  logic [1:0]    dm0_nxt, dm1_nxt;
  logic          dq_oe_nxt, dqs_oe_nxt, dqs_toggle_nxt, proto_err_nxt;

  // Occupancy flags; space freed by a pop is only visible next cycle
  assign wready   = (count != CW'(FIFO_DEPTH));
  assign write_ok = (count >= CW'(BURST_WORDS));
  assign push     = wvalid && wready;
  assign head     = mem[rd_ptr];
  assign go_ok    = write_go && (state == S_IDLE) && write_ok;

  // FIFO storage; {mask, data} per entry, no reset needed on contents
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {wmask, wdata};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Next state, then output values for the cycle that state will occupy
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    beat_nxt       = beat;
    pop            = 1'b0;
    d0_nxt         = '0;
    d1_nxt         = '0;
    dm0_nxt        = 2'b11;
    dm1_nxt        = 2'b11;
    dq_oe_nxt      = 1'b0;
    dqs_oe_nxt     = 1'b0;
    dqs_toggle_nxt = 1'b0;
    proto_err_nxt  = proto_err | (write_go && !go_ok);

    case (state)
      S_IDLE: begin
        if (go_ok) begin
          if (WRITE_LATENCY == 1) begin
            state_nxt = S_PRE;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = 3'(WRITE_LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd0) state_nxt = S_PRE;
      end
      S_PRE: begin
        state_nxt = S_DATA;
        beat_nxt  = '0;
      end
      S_DATA: begin
        if (beat == BW'(BURST_WORDS - 1)) state_nxt = S_POST;
        else                              beat_nxt  = beat + BW'(1);
      end
      S_POST:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_PRE: dqs_oe_nxt = 1'b1;
      S_DATA: begin
        pop            = 1'b1;
        d0_nxt         = head[31:16];
        d1_nxt         = head[15:0];
        dm0_nxt        = head[35:34];
        dm1_nxt        = head[33:32];
        dq_oe_nxt      = 1'b1;
        dqs_oe_nxt     = 1'b1;
        dqs_toggle_nxt = 1'b1;
      end
      S_POST:  dqs_oe_nxt = 1'b1;
      default: ;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      beat       <= '0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      d0         <= '0;
      d1         <= '0;
      dm0        <= 2'b11;
      dm1        <= 2'b11;
      dq_oe      <= 1'b0;
      dqs_oe     <= 1'b0;
      dqs_toggle <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      beat       <= beat_nxt;
      busy       <= (state_nxt != S_IDLE);
      proto_err  <= proto_err_nxt;
      d0         <= d0_nxt;
      d1         <= d1_nxt;
      dm0        <= dm0_nxt;
      dm1        <= dm1_nxt;
      dq_oe      <= dq_oe_nxt;
      dqs_oe     <= dqs_oe_nxt;
      dqs_toggle <= dqs_toggle_nxt;
    end
  end

endmodule

// File: doc/hpdmc_odatapath16.md
Name: hpdmc_odatapath16

Overview:
- Write-direction datapath for the 16-bit DDR SDRAM controller; the transmit counterpart of the 16-bit DDR input register array.
- Buffers 32-bit write words from the bus-side engine and splits each word into rising- and falling-edge 16-bit halves for the ODDR2 output registers.
- When the command scheduler issues a write, it sequences DQ/DQS/DM output enables through preamble, burst and postamble.

Parameters:
- BURST_WORDS, 4, 32-bit words per write burst (one per sys_clk; 4 = DDR burst length 8); power of two, 2..8.
- FIFO_DEPTH, 8, write FIFO depth in 32-bit words; power of two, >= BURST_WORDS.
- WRITE_LATENCY, 1, sys_clk cycles from accepted write_go to DQS preamble; range 1..7.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  reset.
- wdata  in  32  write word; [31:16] rising-edge half, [15:0] falling-edge half.
- wmask  in  4  byte mask per word; 1 = byte not written.
- wvalid  in  1  wdata/wmask valid.
- wready  out  1  FIFO can accept a word.
- write_go  in  1  single-cycle pulse from the scheduler when a WRITE command is issued.
- write_ok  out  1  FIFO holds >= BURST_WORDS words.
- busy  out  1  burst sequence in progress (state != IDLE).
- proto_err  out  1  sticky; write_go was ignored.
- d0  out  16  to ODDR2 D0 (rising-edge DQ).
- d1  out  16  to ODDR2 D1 (falling-edge DQ).
- dm0  out  2  rising-edge DM.
- dm1  out  2  falling-edge DM.
- dq_oe  out  1  DQ/DM output enable.
- dqs_oe  out  1  DQS output enable.
- dqs_toggle  out  1  DQS ODDR2 drives 1/0 when high, 0/0 when low.

Behaviour:
- Reset is synchronous, active-high, on sys_rst sampled at sys_clk.
- Reset values:
  - FIFO empty, state IDLE, proto_err 0.
  - d0 = d1 = 0; dm0 = dm1 = 2'b11.
  - dq_oe = dqs_oe = dqs_toggle = 0; busy 0.
  - wready 1 (when FIFO_DEPTH > 0); write_ok 0.
- Reset asserted mid-burst aborts the burst immediately. All of the above take effect on the next edge, and buffered words are discarded.
- FIFO:
  - A push occurs when wvalid && wready.
  - wready = !full, combinational from the occupancy count. A pop in the same cycle does not free space for a push that cycle.
  - write_ok = (count >= BURST_WORDS), combinational.
  - Count is width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- write_go handling:
  - Accepted only when state == IDLE && write_ok.
  - Any other write_go is ignored, and proto_err is set on the next edge. proto_err clears only on reset.
- FSM (all outputs registered; T = edge sampling an accepted write_go):
  - IDLE: all outputs at idle values. On accept: if WRITE_LATENCY == 1, go to PRE, else go to WAIT with cnt = WRITE_LATENCY-2.
  - WAIT: outputs idle. Decrement cnt; go to PRE when cnt == 0.
  - PRE (visible cycle T+WRITE_LATENCY): dqs_oe = 1, dqs_toggle = 0, dq_oe = 0. Go to DATA with beat = 0.
  - DATA (cycles T+WL+1 .. T+WL+BURST_WORDS):
    - Pop one word per cycle.
    - d0 = wdata[31:16], d1 = wdata[15:0], dm0 = wmask[3:2], dm1 = wmask[1:0].
    - dq_oe = dqs_oe = dqs_toggle = 1.
    - Go to POST after beat == BURST_WORDS-1.
  - POST (one cycle): dqs_oe = 1, dqs_toggle = 0, dq_oe = 0, d0/d1 = 0, dm = 2'b11. Return to IDLE.
- busy = 1 in WAIT/PRE/DATA/POST. A new write_go is accepted earliest in the IDLE cycle after POST.
- Underrun cannot occur: an accepted burst's words are already resident. Pushes during the burst are allowed.
- FIFO words are emitted strictly in push order. The mask passes through unmodified.

Test Plan:
- Reset, then push 0x11112222 m0, 0x33334444 m0, 0x55556666 m4'b1000, 0x77778888 m0; write_go when write_ok=1 (WL=1) -> PRE at T+1; DATA T+2..T+5 with d0/d1 = 1111/2222 … 7777/8888, dm0=2'b10 on beat 3; POST T+6; IDLE T+7; FIFO empty.
- Push 3 words, pulse write_go -> ignored, busy stays 0, proto_err=1 and stays 1; push a 4th word -> write_ok=1.
- Fill 8 words -> wready=0; a 9th wvalid is not accepted; two bursts back-to-back (second write_go in the IDLE cycle after POST) -> 8 words out in order.
- WRITE_LATENCY=3: write_go at T -> outputs idle T+1..T+2, PRE at T+3, first data T+4.
- write_go during DATA with 4 more words buffered -> ignored, proto_err=1, burst completes unaffected.
- Assert sys_rst on DATA beat 1 -> next cycle all outputs idle, dm=2'b11, FIFO count 0, wready=1, proto_err=0.
